// File: rtl/sram_ctrl_pkg.sv
// Shared widths and request bundle for the port-0 controller of the 32x256 1RW1R SRAM macro.
package sram_ctrl_pkg;

   localparam int SRAM_ADDR_WIDTH = 8;
   localparam int SRAM_DATA_WIDTH = 32;
   localparam int SRAM_NUM_WMASKS = 4;

   typedef struct packed {
      logic                       we;
      logic [SRAM_NUM_WMASKS-1:0] wmask;
      logic [SRAM_ADDR_WIDTH-1:0] addr;
      logic [SRAM_DATA_WIDTH-1:0] wdata;
   } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Circular-buffer response FIFO; the caller guarantees no push on full and no pop on empty.
module sram_rsp_fifo #(
   parameter  int DEPTH = 3,
   parameter  int WIDTH = 32,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             valid,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; an entry is only visible after it has been written, so
   // resetting the pointers and count is enough and keeps the array a plain RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign valid    = (count != '0);
   assign pop_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sram_1rw_port_ctrl.sv
// Valid/ready front end for SRAM port 0: drives the macro in the accept cycle and returns
// read data through a credit-protected response FIFO.
module sram_1rw_port_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
   parameter int NUM_WMASKS = SRAM_NUM_WMASKS,
   parameter int RSP_DEPTH  = 3
) (
   input  logic                  clk0,
   input  logic                  rstb0,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [NUM_WMASKS-1:0] req_wmask,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  csb0,
   output logic                  web0,
   output logic [NUM_WMASKS-1:0] wmask0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);

   localparam int CW = $clog2(RSP_DEPTH + 1);

   sram_req_t     req;
   logic          fire;
   logic          rd_inflight;
   logic [CW-1:0] count;

   // A read in flight already owns a FIFO slot, so it is counted as a credit in use.
   assign req_ready = rstb0 && ((int'(count) + int'(rd_inflight)) < RSP_DEPTH);
   assign fire      = req_valid && req_ready;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      req    = '{we: req_we, wmask: req_wmask, addr: req_addr, wdata: req_wdata};
      csb0   = 1'b1;
      web0   = 1'b1;
      wmask0 = '0;
      addr0  = '0;
      din0   = '0;
      if (rstb0) begin
         csb0  = !fire;
         web0  = !(fire && req.we);
         addr0 = req.addr;
         din0  = req.wdata;
         if (req.we) wmask0 = req.wmask;
      end
   end

   // dout0 is only meaningful in the cycle after a read accept.
   always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) rd_inflight <= 1'b0;
      else        rd_inflight <= fire && !req_we;
   end

   sram_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk       (clk0),
      .rst_n     (rstb0),
      .push      (rd_inflight),
      .push_data (dout0),
      .pop       (rsp_valid && rsp_ready),
      .pop_data  (rsp_rdata),
      .valid     (rsp_valid),
      .count     (count)
   );

endmodule

// File: tb/tb_sram_1rw_port_ctrl.sv
// Directed bench for sram_1rw_port_ctrl with a behavioural model of the macro's port 0.
module tb_sram_1rw_port_ctrl;

   logic        clk0 = 1'b0;
   logic        rstb0;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [3:0]  req_wmask;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        csb0;
   logic        web0;
   logic [3:0]  wmask0;
   logic [7:0]  addr0;
   logic [31:0] din0;
   logic [31:0] dout0;

   int checks   = 0;
   int failures = 0;

   always #5 clk0 = ~clk0;

   sram_1rw_port_ctrl dut (
      .clk0      (clk0),
      .rstb0     (rstb0),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_wmask (req_wmask),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .csb0      (csb0),
      .web0      (web0),
      .wmask0    (wmask0),
      .addr0     (addr0),
      .din0      (din0),
      .dout0     (dout0)
   );

   // Macro model: request latched at posedge, write lands at the following negedge,
   // read data valid for the whole following cycle and X otherwise.
   logic [31:0] mem [256];
   logic        lat_csb = 1'b1;
   logic        lat_web = 1'b1;
   logic [3:0]  lat_wmask = '0;
   logic [7:0]  lat_addr = '0;
   logic [31:0] lat_din = '0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
   end

   always @(posedge clk0) begin
      lat_csb   <= csb0;
      lat_web   <= web0;
      lat_wmask <= wmask0;
      lat_addr  <= addr0;
      lat_din   <= din0;
   end

   always @(negedge clk0) begin
      if (!lat_csb && !lat_web)
         for (int b = 0; b < 4; b++)
            if (lat_wmask[b]) mem[lat_addr][b*8 +: 8] = lat_din[b*8 +: 8];
   end

   assign dout0 = (!lat_csb && lat_web) ? mem[lat_addr] : 'x;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk0);
      #1;
   endtask

   // Credit must keep the FIFO within bounds and its head defined whenever it is presented.
   always @(negedge clk0) begin
      if (rstb0 === 1'b1) begin
         check("fifo_bound", 32'(dut.u_fifo.count <= 3), 32'd1);
         if (rsp_valid) check("rdata_known", 32'($isunknown(rsp_rdata)), 32'd0);
      end
   end

   int acc;

   initial begin
      rstb0     = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_wmask = 4'hF;
      req_addr  = 8'h55;
      req_wdata = 32'h1234_5678;
      rsp_ready = 1'b0;

      // Reset held for three cycles with a pending request
      repeat (3) step();
      @(negedge clk0);
      check("rst_csb0", 32'(csb0), 32'd1);
      check("rst_web0", 32'(web0), 32'd1);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_wmask0", 32'(wmask0), 32'd0);
      check("rst_addr0", 32'(addr0), 32'd0);
      check("rst_din0", din0, 32'd0);
      step();
      req_valid = 1'b0;
      rstb0     = 1'b1;
      @(negedge clk0);
      check("rel_req_ready", 32'(req_ready), 32'd1);
      check("idle_csb0", 32'(csb0), 32'd1);
      step();

      // Write 0x10 then read it back the next cycle
      req_valid = 1'b1; req_we = 1'b1; req_wmask = 4'hF; req_addr = 8'h10; req_wdata = 32'hDEAD_BEEF;
      @(negedge clk0);
      check("wr_ready", 32'(req_ready), 32'd1);
      check("wr_csb0", 32'(csb0), 32'd0);
      check("wr_web0", 32'(web0), 32'd0);
      check("wr_wmask0", 32'(wmask0), 32'hF);
      check("wr_addr0", 32'(addr0), 32'h10);
      check("wr_din0", din0, 32'hDEAD_BEEF);
      step();
      req_we = 1'b0; req_wdata = 32'h0;
      @(negedge clk0);
      check("rd_csb0", 32'(csb0), 32'd0);
      check("rd_web0", 32'(web0), 32'd1);
      check("rd_wmask0", 32'(wmask0), 32'd0);
      step();
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk0);
      check("raw_lat1_valid", 32'(rsp_valid), 32'd0);
      step();
      @(negedge clk0);
      check("raw_lat2_valid", 32'(rsp_valid), 32'd1);
      check("raw_data", rsp_rdata, 32'hDEAD_BEEF);
      step();
      @(negedge clk0);
      check("raw_drain", 32'(rsp_valid), 32'd0);
      check("ready_without_valid", 32'(req_ready), 32'd1);
      step();

      // Byte mask merge, then a zero-mask write that must change nothing
      req_valid = 1'b1; req_we = 1'b1; req_wmask = 4'hF; req_addr = 8'h20; req_wdata = 32'h1122_3344;
      step();
      req_wmask = 4'b0101; req_wdata = 32'hAABB_CCDD;
      step();
      req_wmask = 4'b0000; req_wdata = 32'hFFFF_FFFF;
      @(negedge clk0);
      check("wm0_csb0", 32'(csb0), 32'd0);
      check("wm0_web0", 32'(web0), 32'd0);
      check("wm0_wmask0", 32'(wmask0), 32'd0);
      step();
      req_we = 1'b0;
      step();
      req_valid = 1'b0;
      step();
      @(negedge clk0);
      check("mask_valid", 32'(rsp_valid), 32'd1);
      check("mask_data", rsp_rdata, 32'h11BB_33DD);
      step();

      // Sixteen back-to-back reads with the consumer always ready
      rsp_ready = 1'b1;
      for (int k = 0; k < 18; k++) begin
         req_valid = (k < 16);
         req_we    = 1'b0;
         req_addr  = 8'(k);
         @(negedge clk0);
         if (k < 16) check("stream_ready", 32'(req_ready), 32'd1);
         if (k < 2) begin
            check("stream_early", 32'(rsp_valid), 32'd0);
         end else begin
            check("stream_valid", 32'(rsp_valid), 32'd1);
            check("stream_data", rsp_rdata, 32'hA500_0000 + 32'(k - 2));
         end
         step();
      end
      req_valid = 1'b0;
      @(negedge clk0);
      check("stream_end", 32'(rsp_valid), 32'd0);
      step();

      // Backpressure: only RSP_DEPTH reads may be accepted while the consumer stalls
      rsp_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         req_valid = 1'b1;
         req_addr  = 8'(3 + acc);
         @(negedge clk0);
         if (req_ready) acc++;
         if (c == 5) begin
            check("bp_ready_low", 32'(req_ready), 32'd0);
            check("bp_hold", rsp_rdata, 32'hA500_0003);
         end
         step();
      end
      check("bp_accepted", 32'(acc), 32'd3);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk0);
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_data", rsp_rdata, 32'hA500_0003 + 32'(j));
         step();
      end
      @(negedge clk0);
      check("bp_empty", 32'(rsp_valid), 32'd0);
      check("bp_resume", 32'(req_ready), 32'd1);
      step();

      // Reset the cycle after a read accept: nothing may come back
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h07;
      @(negedge clk0);
      check("mid_accept", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      rstb0     = 1'b0;
      @(negedge clk0);
      check("mid_rst_ready", 32'(req_ready), 32'd0);
      check("mid_rst_csb0", 32'(csb0), 32'd1);
      step();
      rstb0 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk0);
         check("mid_no_rsp", 32'(rsp_valid), 32'd0);
         check("mid_count", 32'(dut.u_fifo.count), 32'd0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_1rw_port_ctrl.md
Name: sram_1rw_port_ctrl

Overview:
- Request/response front end for port 0 of the 32x256 1RW1R SRAM macro.
- Takes valid/ready read and write requests with byte masks and drives csb0/web0/wmask0/addr0/din0 combinationally in the accept cycle.
- Samples the macro's dout0 one clock later and returns read data through a credit-protected response FIFO, so backpressure never loses data.
- Sits between the bus-side agent and the macro; port 1 is untouched.

Parameters:
- ADDR_WIDTH, 8, word address width.
- DATA_WIDTH, 32, data word width.
- NUM_WMASKS, 4, byte-lane write mask width (DATA_WIDTH/8).
- RSP_DEPTH, 3, response FIFO entries. Must be >=3 for back-to-back reads; >=2 is legal.

Ports:
- clk0  in  1  Single clock, shared with the macro clk0.
- rstb0  in  1  Asynchronous, active-low reset.
- req_valid  in  1  Request present.
- req_ready  out  1  Request accepted when req_valid && req_ready at posedge.
- req_we  in  1  1 = write, 0 = read.
- req_wmask  in  NUM_WMASKS  Byte enables; used for writes only.
- req_addr  in  ADDR_WIDTH  Word address.
- req_wdata  in  DATA_WIDTH  Write data.
- rsp_valid  out  1  Read data available.
- rsp_ready  in  1  Consumer takes data when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  Read data (FIFO head).
- csb0  out  1  To macro, active-low chip select.
- web0  out  1  To macro, active-low write enable.
- wmask0  out  NUM_WMASKS  To macro.
- addr0  out  ADDR_WIDTH  To macro.
- din0  out  DATA_WIDTH  To macro.
- dout0  in  DATA_WIDTH  From macro.

Behaviour:
- Reset, asynchronous with rstb0=0:
  - FIFO empty: rsp_valid=0, count=0, rd_inflight=0, rsp_rdata=0.
  - req_ready=0 while rstb0=0.
  - csb0=1, web0=1, wmask0=0, addr0=0, din0=0 (gated by rstb0).
- Request acceptance:
  - req_ready = rstb0 && (count + rd_inflight < RSP_DEPTH).
  - req_ready never depends on req_valid, req_we or rsp_ready.
  - Writes consume no credit but obey the same req_ready.
- Macro drive, combinational:
  - fire = req_valid && req_ready.
  - csb0 = !fire; web0 = !(fire && req_we).
  - wmask0 = req_we ? req_wmask : 0.
  - addr0 = req_addr; din0 = req_wdata.
  - When fire=0, addr0/din0 still follow the request inputs (don't care, since csb0=1).
- Read timing, with accept in cycle N:
  - The macro registers the request at the end of cycle N; rd_inflight=1 during N+1.
  - At the posedge ending N+1, dout0 is pushed into the FIFO.
  - rsp_valid=1 from cycle N+2. Read latency is 2 cycles.
- dout0 is sampled only when rd_inflight=1. dout0 is X outside read slots and must never enter the FIFO.
- Write timing: accepted in cycle N, memory updated at the negedge inside N+1. There is no response.
- RAW hazard:
  - A read accepted in cycle N+1 to the same address as a write in N returns the new data. No forwarding is needed.
  - Same-cycle RAW is impossible (single port).
- Writes with wmask=0 are issued (csb0=0, web0=0) and modify nothing.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Push and pop in the same cycle leaves count unchanged.
  - Pop on empty and push on full cannot occur: credit guarantees it, and the bench must assert it.
  - rsp_rdata holds its value while rsp_valid && !rsp_ready.
- Throughput: with RSP_DEPTH>=3 and rsp_ready held at 1, one read per cycle indefinitely.
- Reset mid-operation: in-flight read and buffered data are discarded, with no response after rstb0 deasserts.

Decomposition:
- Shared package sram_ctrl_pkg:
  - SRAM_ADDR_WIDTH=8, SRAM_DATA_WIDTH=32, SRAM_NUM_WMASKS=4.
  - Request struct type {we, wmask, addr, wdata}.
- One sub-module: sram_rsp_fifo.
  - Parameterised DEPTH/WIDTH synchronous FIFO with async active-low reset.
  - Exposes count, push, pop.

Test Plan:
- Reset: hold rstb0=0 for 3 cycles with req_valid=1 -> csb0=1, req_ready=0, rsp_valid=0. Release -> req_ready=1 next cycle.
- Write then read: write addr 0x10 data 0xDEADBEEF mask 4'hF, then read 0x10 next cycle -> rsp_rdata=0xDEADBEEF, rsp_valid exactly 2 cycles after read accept.
- Byte mask: preload 0x11223344 at 0x20, write 0xAABBCCDD mask 4'b0101 -> read returns 0x11BB33DD.
- Streaming: rsp_ready=1, 16 back-to-back reads of addr 0..15 -> 16 consecutive rsp_valid cycles, data in order, req_ready never drops.
- Backpressure: rsp_ready=0, issue reads -> exactly 3 accepted, req_ready=0. Raise rsp_ready -> 3 responses in order, then acceptance resumes.
- Reset mid-read: assert rstb0 the cycle after a read accept -> no rsp_valid after release; FIFO count=0.
